user_rw_reg_bank: RTL and testbench

- Multi-channel JTAG user data register bank with readback. Generalises the single sipo user write register to NCH registers of WIDTH bits each.
- Adds capture of the current contents for readback, a shift-length guard that blocks truncated or overlong scans from updating, per-channel update strobes and optional TMR scrubbing.
- Sits behind the BSCAN user instruction decode. All logic runs in the TCK domain; SHIFT, CAPTURE and UPDATE arrive as TCK-synchronous single-cycle state qualifiers.

---
 rtl/user_reg_pkg.sv | 32 +++
 rtl/tmr_vote_reg.sv | 50 +++++
 rtl/user_rw_reg_bank.sv | 144 ++++++++++++++
 tb/tb_user_rw_reg_bank.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/user_reg_pkg.sv
// rtl/user_reg_pkg.sv - state encoding and helper functions for the JTAG user register bank
package user_reg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RSVD  = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) r = r + 1;
        end
        return r;
    endfunction

    function automatic logic [3:0] onehot_idx(input logic [15:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) r = 4'(i);
        end
        return r;
    endfunction

    function automatic logic is_onehot(input logic [15:0] v);
        return (v != 16'd0) && ((v & (v - 16'd1)) == 16'd0);
    endfunction

endpackage

// File: rtl/tmr_vote_reg.sv
// rtl/tmr_vote_reg.sv - parallel output register, optionally triplicated with vote and scrub
module tmr_vote_reg #(
    parameter int               WIDTH = 16,
    parameter int               TMR   = 0,
    parameter logic [WIDTH-1:0] DEF   = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (TMR != 0) begin : g_tmr
        (* syn_preserve = 1, syn_keep = 1 *) logic [WIDTH-1:0] cp0;
        (* syn_preserve = 1, syn_keep = 1 *) logic [WIDTH-1:0] cp1;
        (* syn_preserve = 1, syn_keep = 1 *) logic [WIDTH-1:0] cp2;
        logic [WIDTH-1:0] vote;

        assign vote = (cp0 & cp1) | (cp1 & cp2) | (cp0 & cp2);
        assign q    = vote;

        // Idle cycles write the voted value back so a single upset heals next edge.
        always_ff @(posedge clk) begin
            if (rst) begin
                cp0 <= DEF;
                cp1 <= DEF;
                cp2 <= DEF;
            end else if (we) begin
                cp0 <= d;
                cp1 <= d;
                cp2 <= d;
            end else begin
                cp0 <= vote;
                cp1 <= vote;
                cp2 <= vote;
            end
        end
    end else begin : g_plain
        logic [WIDTH-1:0] r;

        assign q = r;

        always_ff @(posedge clk) begin
            if (rst)     r <= DEF;
            else if (we) r <= d;
        end
    end

endmodule

// File: rtl/user_rw_reg_bank.sv
// rtl/user_rw_reg_bank.sv - multi-channel JTAG user data register bank with readback
module user_rw_reg_bank
    import user_reg_pkg::*;
#(
    parameter int                   WIDTH     = 16,
    parameter int                   NCH       = 4,
    parameter logic [NCH*WIDTH-1:0] DEF_VALUE = '0,
    parameter int                   TMR       = 0
) (
    input  logic                 TCK,
    input  logic                 RST,
    input  logic                 SEL,
    input  logic [NCH-1:0]       FSEL,
    input  logic                 CAPTURE,
    input  logic                 SHIFT,
    input  logic                 UPDATE,
    input  logic                 TDI,
    output logic                 TDO,
    input  logic [NCH-1:0]       LOAD,
    input  logic [NCH*WIDTH-1:0] PI,
    output logic [NCH*WIDTH-1:0] PO,
    output logic [NCH-1:0]       UPD_STRB,
    output logic                 LEN_ERR,
    input  logic                 ERR_CLR
);

    localparam int CNTW    = clog2(WIDTH + 2);
    localparam int CHW     = (NCH > 1) ? clog2(NCH) : 1;
    localparam int CNT_MAX = WIDTH + 1;

    state_t           state_q, state_d;
    logic [CHW-1:0]   ch_q, ch_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [NCH-1:0]   upd_strb_q, upd_strb_d;
    logic             len_err_q;
    logic             err_set;
    logic             jtag_wr;
    logic [15:0]      fsel_ext;
    logic             fsel_ok;
    logic [CHW-1:0]   fsel_idx;
    logic [WIDTH-1:0] po_arr [NCH];

    assign fsel_ext = 16'(FSEL);
    assign fsel_ok  = is_onehot(fsel_ext);
    assign fsel_idx = CHW'(onehot_idx(fsel_ext));

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        err_set    = 1'b0;
        jtag_wr    = 1'b0;
        upd_strb_d = '0;
        case (state_q)
            IDLE: begin
                if (CAPTURE && SEL) begin
                    if (fsel_ok) begin
                        ch_d    = fsel_idx;
                        sr_d    = po_arr[fsel_idx];
                        cnt_d   = '0;
                        state_d = ARMED;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            ARMED: begin
                if (!SEL) begin
                    state_d = IDLE;
                end else if (CAPTURE) begin
                    if (fsel_ok) begin
                        ch_d  = fsel_idx;
                        sr_d  = po_arr[fsel_idx];
                        cnt_d = '0;
                    end else begin
                        err_set = 1'b1;
                        state_d = IDLE;
                    end
                end else if (UPDATE) begin
                    // Only an exact-length scan may reach the output register.
                    if (cnt_q == CNTW'(WIDTH)) jtag_wr = 1'b1;
                    else                       err_set = 1'b1;
                    state_d = IDLE;
                end else if (SHIFT) begin
                    sr_d = {TDI, sr_q[WIDTH-1:1]};
                    if (cnt_q != CNTW'(CNT_MAX)) cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (jtag_wr) upd_strb_d = NCH'(1) << ch_q;
    end

    always_ff @(posedge TCK) begin
        if (RST) begin
            state_q    <= IDLE;
            ch_q       <= '0;
            sr_q       <= '0;
            cnt_q      <= '0;
            upd_strb_q <= '0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            upd_strb_q <= upd_strb_d;
            if (err_set)      len_err_q <= 1'b1;
            else if (ERR_CLR) len_err_q <= 1'b0;
        end
    end

    // A JTAG update to a channel overrides a same-cycle LOAD of that channel.
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic             hit;
        logic             we;
        logic [WIDTH-1:0] d;

        assign hit = jtag_wr && (ch_q == CHW'(i));
        assign we  = hit || LOAD[i];
        assign d   = hit ? sr_q : PI[i*WIDTH +: WIDTH];

        tmr_vote_reg #(
            .WIDTH (WIDTH),
            .TMR   (TMR),
            .DEF   (DEF_VALUE[i*WIDTH +: WIDTH])
        ) u_reg (
            .clk (TCK),
            .rst (RST),
            .we  (we),
            .d   (d),
            .q   (po_arr[i])
        );

        assign PO[i*WIDTH +: WIDTH] = po_arr[i];
    end

    assign TDO      = (state_q == ARMED) && SEL && sr_q[0];
    assign UPD_STRB = upd_strb_q;
    assign LEN_ERR  = len_err_q;

endmodule

// File: tb/tb_user_rw_reg_bank.sv
// tb/tb_user_rw_reg_bank.sv - directed self-checking bench for user_rw_reg_bank
module tb_user_rw_reg_bank;

    localparam logic [63:0] DEF = 64'h0004_0003_0002_0001;

    logic        TCK = 1'b0;
    logic        RST, SEL, CAPTURE, SHIFT, UPDATE, TDI, ERR_CLR;
    logic [3:0]  FSEL, LOAD;
    logic [63:0] PI;
    logic        TDO, LEN_ERR, tdo_t, err_t;
    logic [63:0] PO, po_t;
    logic [3:0]  UPD_STRB, strb_t;

    int checks = 0;
    int errors = 0;
    logic [15:0] rd;
    logic        tdo_seen;

    always #5 TCK = ~TCK;

    user_rw_reg_bank #(.WIDTH(16), .NCH(4), .DEF_VALUE(DEF), .TMR(0)) dut (
        .TCK(TCK), .RST(RST), .SEL(SEL), .FSEL(FSEL), .CAPTURE(CAPTURE),
        .SHIFT(SHIFT), .UPDATE(UPDATE), .TDI(TDI), .TDO(TDO), .LOAD(LOAD),
        .PI(PI), .PO(PO), .UPD_STRB(UPD_STRB), .LEN_ERR(LEN_ERR), .ERR_CLR(ERR_CLR)
    );

    user_rw_reg_bank #(.WIDTH(16), .NCH(4), .DEF_VALUE(DEF), .TMR(1)) dut_t (
        .TCK(TCK), .RST(RST), .SEL(SEL), .FSEL(FSEL), .CAPTURE(CAPTURE),
        .SHIFT(SHIFT), .UPDATE(UPDATE), .TDI(TDI), .TDO(tdo_t), .LOAD(LOAD),
        .PI(PI), .PO(po_t), .UPD_STRB(strb_t), .LEN_ERR(err_t), .ERR_CLR(ERR_CLR)
    );

    task automatic tick();
        @(posedge TCK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic capture(input logic [3:0] f);
        FSEL = f;
        CAPTURE = 1'b1;
        tick();
        CAPTURE = 1'b0;
    endtask

    task automatic shift_bits(input logic [15:0] data, input int n, output logic [15:0] rb);
        rb = '0;
        SHIFT = 1'b1;
        for (int i = 0; i < n; i++) begin
            TDI = (i < 16) ? data[i] : 1'b0;
            if (i < 16) rb[i] = TDO;
            tick();
        end
        SHIFT = 1'b0;
        TDI = 1'b0;
    endtask

    task automatic update();
        UPDATE = 1'b1;
        tick();
        UPDATE = 1'b0;
    endtask

    task automatic clear_err();
        ERR_CLR = 1'b1;
        tick();
        ERR_CLR = 1'b0;
    endtask

    initial begin
        RST = 1'b1; SEL = 1'b0; CAPTURE = 1'b0; SHIFT = 1'b0; UPDATE = 1'b0;
        TDI = 1'b0; ERR_CLR = 1'b0; FSEL = 4'b0000; LOAD = 4'b0000; PI = '0;
        tick();
        tick();
        RST = 1'b0;
        SEL = 1'b1;
        tick();
        chk("reset_po", PO, DEF);
        chk("reset_po_tmr", po_t, DEF);
        chk("reset_tdo", 64'(TDO), 64'd0);
        chk("reset_len_err", 64'(LEN_ERR), 64'd0);
        chk("reset_strb", 64'(UPD_STRB), 64'd0);

        // full write of ch2 with readback of its default
        capture(4'b0100);
        shift_bits(16'hA5C3, 16, rd);
        chk("wr_readback_old", 64'(rd), 64'h0003);
        update();
        chk("wr_po", PO, 64'h0004_A5C3_0002_0001);
        chk("wr_strb", 64'(UPD_STRB), 64'h4);
        tick();
        chk("wr_strb_one_cycle", 64'(UPD_STRB), 64'h0);

        // second scan reads back the new value, then aborts via SEL drop
        capture(4'b0100);
        shift_bits(16'h0000, 16, rd);
        chk("readback_new", 64'(rd), 64'hA5C3);
        SEL = 1'b0;
        tick();
        SEL = 1'b1;
        chk("abort_po", PO, 64'h0004_A5C3_0002_0001);
        chk("abort_no_err", 64'(LEN_ERR), 64'd0);

        // short scan
        capture(4'b0001);
        shift_bits(16'hFFFF, 15, rd);
        update();
        chk("short_po", PO, 64'h0004_A5C3_0002_0001);
        chk("short_err", 64'(LEN_ERR), 64'd1);
        chk("short_strb", 64'(UPD_STRB), 64'h0);
        clear_err();
        chk("short_err_clr", 64'(LEN_ERR), 64'd0);

        // overlong scan
        capture(4'b0001);
        shift_bits(16'hFFFF, 17, rd);
        update();
        chk("long_po", PO, 64'h0004_A5C3_0002_0001);
        chk("long_err", 64'(LEN_ERR), 64'd1);
        chk("long_strb", 64'(UPD_STRB), 64'h0);
        clear_err();
        chk("long_err_clr", 64'(LEN_ERR), 64'd0);

        // set beats clear in the same cycle
        FSEL = 4'b0000;
        CAPTURE = 1'b1;
        ERR_CLR = 1'b1;
        tick();
        CAPTURE = 1'b0;
        ERR_CLR = 1'b0;
        chk("err_set_over_clr", 64'(LEN_ERR), 64'd1);
        clear_err();

        // select error with two FSEL bits
        capture(4'b0011);
        chk("sel_err", 64'(LEN_ERR), 64'd1);
        tdo_seen = 1'b0;
        SHIFT = 1'b1;
        for (int i = 0; i < 16; i++) begin
            TDI = 1'b1;
            tdo_seen = tdo_seen | TDO;
            tick();
        end
        SHIFT = 1'b0;
        chk("sel_err_tdo", 64'(tdo_seen), 64'd0);
        update();
        chk("sel_err_po", PO, 64'h0004_A5C3_0002_0001);
        chk("sel_err_strb", 64'(UPD_STRB), 64'h0);
        clear_err();

        // collision: LOAD ch0+ch2 during JTAG update of ch2
        capture(4'b0100);
        shift_bits(16'hBEEF, 16, rd);
        LOAD = 4'b0101;
        PI = 64'h0000_2222_0000_1111;
        update();
        LOAD = 4'b0000;
        chk("coll_po", PO, 64'h0004_BEEF_0002_1111);
        chk("coll_strb", 64'(UPD_STRB), 64'h4);
        LOAD = 4'b1000;
        PI = 64'h7777_0000_0000_0000;
        tick();
        LOAD = 4'b0000;
        chk("load_po", PO, 64'h7777_BEEF_0002_1111);
        chk("load_no_strb", 64'(UPD_STRB), 64'h0);

        // reset mid-scan, then a full scan of ch1
        capture(4'b0010);
        shift_bits(16'hFFFF, 8, rd);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("midrst_po", PO, DEF);
        chk("midrst_idle_tdo", 64'(TDO), 64'd0);
        capture(4'b0010);
        shift_bits(16'h1234, 16, rd);
        chk("midrst_readback", 64'(rd), 64'h0002);
        update();
        chk("midrst_wr_po", PO, 64'h0004_0003_1234_0001);
        chk("tmr_wr_po", po_t, 64'h0004_0003_1234_0001);

        // single-copy upset in the triplicated bank
        force dut_t.g_ch[1].u_reg.g_tmr.cp2 = 16'h1234 ^ 16'h0010;
        #1;
        chk("tmr_upset_masked", po_t, 64'h0004_0003_1234_0001);
        tick();
        release dut_t.g_ch[1].u_reg.g_tmr.cp2;
        tick();
        chk("tmr_scrubbed", 64'(dut_t.g_ch[1].u_reg.g_tmr.cp2), 64'h1234);
        chk("tmr_po_after", po_t, 64'h0004_0003_1234_0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
